regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised integer register file for the RISC-V pipeline: 2 read ports, 1 write port, same-cycle write-to-read bypass, and a per-register pending-write scoreboard. The decode stage reads operands and raises `hazard` when a source has an outstanding write. Issue marks a destination pending; writeback clears it. Replaces the plain 32x32 register file in the ID/WB stages.

## Interface
Parameters:
- `XLEN`, 32, data width in bits.
- `NREGS`, 32, number of architectural registers; power of 2, at least 2.
- `AW`, `$clog2(NREGS)`, register index width; derived, not overridden.
- `BYPASS`, 1, 1 enables the writeback-to-read bypass; 0 disables it.

Ports:
- `clk`, input, 1, single clock; all state updates on the rising edge.
- `rst`, input, 1, synchronous, active-high reset.
- `rs1`, input, AW, read index, port 1.
- `rs2`, input, AW, read index, port 2.
- `data1`, output, XLEN, read data, port 1.
- `data2`, output, XLEN, read data, port 2.
- `busy1`, output, 1, `rs1` has an unresolved pending write.
- `busy2`, output, 1, `rs2` has an unresolved pending write.
- `hazard`, output, 1, `busy1 | busy2`.
- `issue_valid`, input, 1, an instruction with destination `issue_rd` issues this cycle.
- `issue_rd`, input, AW, destination of the issuing instruction.
- `issue_block`, output, 1, the issue is refused (WAW on a pending register).
- `wb_valid`, input, 1, writeback this cycle.
- `wb_rd`, input, AW, writeback destination.
- `wb_data`, input, XLEN, writeback data.

## Operation
- State:
  - `regs[NREGS]`, each XLEN bits wide.
  - `pending[NREGS]`, one bit each.
- Register 0 is hardwired zero:
  - Reads of index 0 always return 0.
  - Writes to index 0 are ignored.
  - `pending[0]` is never set.
- Write:
  - When `wb_valid` is high and `wb_rd != 0`, `regs[wb_rd]` takes `wb_data` at the edge.
  - In the same edge, `pending[wb_rd]` is cleared.
- Read (combinational):
  - `data_n = regs[rs_n]` in the normal case.
  - If `BYPASS=1`, `wb_valid` is high, `wb_rd == rs_n` and `rs_n != 0`, then `data_n = wb_data`.
- Busy:
  - `busy_n = pending[rs_n] & ~bypass_hit_n`.
  - `bypass_hit_n` is the read-bypass condition above; it is always 0 when `BYPASS=0`.
- Issue:
  - `issue_block = issue_valid & pending[issue_rd] & ~(wb_valid & wb_rd == issue_rd)`.
  - An issue is accepted when `issue_valid` is high, `issue_block` is low and `issue_rd != 0`. An accepted issue sets `pending[issue_rd]` at the edge.
  - A blocked issue changes no state. Upstream must hold the instruction and retry.
- Simultaneous events:
  - Issue and writeback to the same register in the same cycle: the issue is not blocked, the register takes `wb_data`, and `pending` ends at 1 (set wins over clear).
  - Issue and writeback to different registers: both take effect.
  - `rs1 == rs2`: both ports return identical data and busy.
- Reset (`rst` high at an edge):
  - All `regs` and all `pending` bits clear to 0.
  - Reset takes priority over a concurrent write or issue in the same cycle; neither takes effect.
  - An in-flight writeback that arrives after reset still writes and clears pending, which is harmless.
- Output values after reset with `wb_valid` low: `data1 = data2 = 0`; `busy1 = busy2 = hazard = issue_block = 0`.

## Timing
- Read latency is 0 cycles, combinational from `rs_n`, `regs`, `pending` and the `wb_*` inputs.
- Write-to-read latency:
  - `BYPASS=1`: 0 cycles (same cycle, via bypass).
  - `BYPASS=0`: 1 cycle (visible after the edge).
- Issue-to-busy latency is 1 cycle: the pending bit is visible the cycle after the accepted issue.
- Writeback-to-unbusy latency:
  - `BYPASS=1`: same cycle.
  - `BYPASS=0`: the next cycle.
- No combinational path from `issue_*` to `data_n` or `busy_n`.

## Test plan
- **Reset:** drive `rst` for 1 cycle with writes active, then read all indices. Required: every `data = 0`, `hazard = 0`, and no write took effect.
- **x0 protection:**
  - `wb_valid=1`, `wb_rd=0`, `wb_data=0xDEADBEEF`, then read `rs1=0`. Required: `data1 = 0`.
  - `issue_rd=0` accepted, then read `rs1=0`. Required: `busy1 = 0`.
- **Bypass:** `BYPASS=1`, `wb_rd=5`, `wb_data=0x1234`, `rs1=5`, all in the same cycle. Required: `data1 = 0x1234` that cycle. With `BYPASS=0`, the old value appears that cycle and `0x1234` the next.
- **Scoreboard:**
  - Issue `rd=7`, then `rs2=7` the next cycle. Required: `busy2 = 1`, `hazard = 1`.
  - Writeback `rd=7` with `wb_data=0x55`. Required: `busy2 = 0` with `data2 = 0x55` in the same cycle (`BYPASS=1`).
- **WAW block:** with `pending[9]` set and no writeback to 9, issue `rd=9`. Required: `issue_block = 1` and pending unchanged. In the cycle where writeback 9 and issue 9 coincide: `issue_block = 0`, `regs[9]` is updated, and `pending[9] = 1` afterwards.
- **Randomized cross-check:** random issue/writeback/read against a reference model (including `rst` mid-stream) for `NREGS = 8, 32`, `XLEN = 16, 32`. Required: zero mismatches over 10k cycles.

Source files
------------

// File: rtl/regfile_sb_if.sv
// Purpose: bundles the read, issue and writeback signals of the scoreboarded register file.
// Latency: wiring only.
// Backpressure: issue_block flows back to the issuer; reads and writebacks are never stalled.
// Ports (master = pipeline side, slave = register file side):
//   rs1/rs2 -> data1/data2, busy1/busy2, hazard  : operand read and RAW hazard
//   issue_valid, issue_rd -> issue_block         : destination reservation
//   wb_valid, wb_rd, wb_data                      : writeback
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [XLEN-1:0] data1;
  logic [XLEN-1:0] data2;
  logic            busy1;
  logic            busy2;
  logic            hazard;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic            issue_block;
  logic            wb_valid;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;

  modport master (
    output rs1, rs2, issue_valid, issue_rd, wb_valid, wb_rd, wb_data,
    input  data1, data2, busy1, busy2, hazard, issue_block
  );

  modport slave (
    input  rs1, rs2, issue_valid, issue_rd, wb_valid, wb_rd, wb_data,
    output data1, data2, busy1, busy2, hazard, issue_block
  );
endinterface

// File: rtl/regfile_sb.sv
// Purpose: 2R/1W integer register file with writeback-to-read bypass and pending-write scoreboard.
// Latency: reads are combinational; writes and issue reservations land at the next rising edge.
// Backpressure: issue_block refuses an issue to a still-pending destination (WAW); upstream holds and retries.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset, clears every register and pending bit
//   bus  - regfile_sb_if slave: read ports, hazard flags, issue and writeback
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1
) (
  input  logic        clk,
  input  logic        rst,
  regfile_sb_if.slave bus
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;

  logic wb_we;
  logic hit1;
  logic hit2;
  logic issue_same_wb;
  logic issue_acc;

  // x0 is never a write target, so a writeback to index 0 neither writes nor bypasses.
  assign wb_we = bus.wb_valid && (bus.wb_rd != AW'(0));

  // wb_rd is non-zero whenever wb_we is set, so a hit can never be on x0.
  assign hit1 = (BYPASS != 0) && wb_we && (bus.wb_rd == bus.rs1);
  assign hit2 = (BYPASS != 0) && wb_we && (bus.wb_rd == bus.rs2);

  assign bus.data1 = (bus.rs1 == AW'(0)) ? '0 : (hit1 ? bus.wb_data : regs_q[bus.rs1]);
  assign bus.data2 = (bus.rs2 == AW'(0)) ? '0 : (hit2 ? bus.wb_data : regs_q[bus.rs2]);

  // A bypassed writeback resolves the hazard in the same cycle.
  assign bus.busy1  = pending_q[bus.rs1] & ~hit1;
  assign bus.busy2  = pending_q[bus.rs2] & ~hit2;
  assign bus.hazard = bus.busy1 | bus.busy2;

  // A writeback to the same register this cycle retires the older producer, so the new issue may proceed.
  assign issue_same_wb   = bus.wb_valid && (bus.wb_rd == bus.issue_rd);
  assign bus.issue_block = bus.issue_valid && pending_q[bus.issue_rd] && !issue_same_wb;
  assign issue_acc       = bus.issue_valid && !bus.issue_block && (bus.issue_rd != AW'(0));

  always_comb begin
    regs_d    = regs_q;
    pending_d = pending_q;
    if (wb_we) begin
      regs_d[bus.wb_rd]    = bus.wb_data;
      pending_d[bus.wb_rd] = 1'b0;
    end
    // Applied after the clear so a coincident issue to the written register stays pending.
    if (issue_acc) begin
      pending_d[bus.issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      pending_q <= '0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Purpose: self-checking bench for regfile_sb; two instances share one stimulus stream.
// Latency: n/a.
// Backpressure: n/a.
// Instance a: XLEN=32, NREGS=32, BYPASS=1.  Instance b: XLEN=16, NREGS=8, BYPASS=0 (indices and data truncated).
module tb_regfile_sb;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1, rs2, issue_rd, wb_rd;
  logic        issue_valid, wb_valid;
  logic [31:0] wb_data;

  int n_cmp;
  int n_fail;

  regfile_sb_if #(.XLEN(32), .AW(5)) if_a ();
  regfile_sb_if #(.XLEN(16), .AW(3)) if_b ();

  assign if_a.rs1         = rs1;
  assign if_a.rs2         = rs2;
  assign if_a.issue_valid = issue_valid;
  assign if_a.issue_rd    = issue_rd;
  assign if_a.wb_valid    = wb_valid;
  assign if_a.wb_rd       = wb_rd;
  assign if_a.wb_data     = wb_data;

  assign if_b.rs1         = rs1[2:0];
  assign if_b.rs2         = rs2[2:0];
  assign if_b.issue_valid = issue_valid;
  assign if_b.issue_rd    = issue_rd[2:0];
  assign if_b.wb_valid    = wb_valid;
  assign if_b.wb_rd       = wb_rd[2:0];
  assign if_b.wb_data     = wb_data[15:0];

  regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(1)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  regfile_sb #(.XLEN(16), .NREGS(8),  .BYPASS(0)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] m_regs [2][32];
  bit          m_pend [2][32];

  function automatic int cfg_nregs(int d);
    return (d == 0) ? 32 : 8;
  endfunction

  function automatic logic [31:0] cfg_mask(int d);
    return (d == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  function automatic int ix(int d, logic [4:0] v);
    return int'(v) % cfg_nregs(d);
  endfunction

  function automatic bit m_hit(int d, logic [4:0] rs);
    return (d == 0) && wb_valid && (ix(d, wb_rd) == ix(d, rs)) && (ix(d, rs) != 0);
  endfunction

  function automatic logic [31:0] m_read(int d, logic [4:0] rs);
    if (ix(d, rs) == 0) return 32'h0;
    if (m_hit(d, rs)) return wb_data & cfg_mask(d);
    return m_regs[d][ix(d, rs)];
  endfunction

  function automatic bit m_busy(int d, logic [4:0] rs);
    return m_pend[d][ix(d, rs)] && !m_hit(d, rs);
  endfunction

  function automatic bit m_block(int d);
    return issue_valid && m_pend[d][ix(d, issue_rd)] &&
           !(wb_valid && (ix(d, wb_rd) == ix(d, issue_rd)));
  endfunction

  // Advance one clock: apply the edge to the model using the inputs held across it.
  task automatic step();
    bit blk;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int i = 0; i < 32; i++) begin
          m_regs[d][i] = 32'h0;
          m_pend[d][i] = 1'b0;
        end
      end else begin
        blk = m_block(d);
        if (wb_valid && ix(d, wb_rd) != 0) begin
          m_regs[d][ix(d, wb_rd)] = wb_data & cfg_mask(d);
          m_pend[d][ix(d, wb_rd)] = 1'b0;
        end
        if (issue_valid && !blk && ix(d, issue_rd) != 0)
          m_pend[d][ix(d, issue_rd)] = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rs1 = 0; rs2 = 0; issue_valid = 0; issue_rd = 0;
    wb_valid = 0; wb_rd = 0; wb_data = 0;
  endtask

  // ---------------- directed tests ----------------
  task automatic test_reset();
    rst = 1; idle(); step(); step(); rst = 0;
    wb_valid = 1; wb_rd = 3; wb_data = 32'hAAAA; issue_valid = 1; issue_rd = 4; step();
    // Reset with a write and an issue active: neither may land.
    rst = 1; wb_valid = 1; wb_rd = 6; wb_data = 32'hBEEF; issue_valid = 1; issue_rd = 7; step();
    rst = 0; idle();
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(i); #1;
      n_cmp++; if (if_a.data1 !== 32'h0) begin n_fail++; $display("FAIL reset_data1 idx%0d: got %h expected 0", i, if_a.data1); end
      n_cmp++; if (if_a.data2 !== 32'h0) begin n_fail++; $display("FAIL reset_data2 idx%0d: got %h expected 0", i, if_a.data2); end
      n_cmp++; if (if_a.hazard !== 1'b0) begin n_fail++; $display("FAIL reset_hazard idx%0d: got %b expected 0", i, if_a.hazard); end
      n_cmp++; if (if_b.data1 !== 16'h0 || if_b.hazard !== 1'b0) begin n_fail++; $display("FAIL reset_b idx%0d: got data %h hazard %b expected 0/0", i, if_b.data1, if_b.hazard); end
      step();
    end
    n_cmp++; if (if_a.issue_block !== 1'b0) begin n_fail++; $display("FAIL reset_issue_block: got %b expected 0", if_a.issue_block); end
  endtask

  task automatic test_x0();
    idle(); wb_valid = 1; wb_rd = 0; wb_data = 32'hDEADBEEF; #1;
    n_cmp++; if (if_a.data1 !== 32'h0) begin n_fail++; $display("FAIL x0_bypass: got %h expected 0", if_a.data1); end
    step(); idle(); #1;
    n_cmp++; if (if_a.data1 !== 32'h0) begin n_fail++; $display("FAIL x0_write: got %h expected 0", if_a.data1); end
    n_cmp++; if (if_b.data1 !== 16'h0) begin n_fail++; $display("FAIL x0_write_b: got %h expected 0", if_b.data1); end
    issue_valid = 1; issue_rd = 0; #1;
    n_cmp++; if (if_a.issue_block !== 1'b0) begin n_fail++; $display("FAIL x0_issue_block: got %b expected 0", if_a.issue_block); end
    step(); idle(); #1;
    n_cmp++; if (if_a.busy1 !== 1'b0 || if_a.hazard !== 1'b0) begin n_fail++; $display("FAIL x0_busy: got busy1 %b hazard %b expected 0/0", if_a.busy1, if_a.hazard); end
    step();
  endtask

  task automatic test_bypass();
    idle(); wb_valid = 1; wb_rd = 5; wb_data = 32'h1234; rs1 = 5; #1;
    n_cmp++; if (if_a.data1 !== 32'h1234) begin n_fail++; $display("FAIL bypass_same_cycle: got %h expected 00001234", if_a.data1); end
    n_cmp++; if (if_b.data1 !== 16'h0) begin n_fail++; $display("FAIL nobypass_old: got %h expected 0000", if_b.data1); end
    step(); idle(); rs1 = 5; #1;
    n_cmp++; if (if_b.data1 !== 16'h1234) begin n_fail++; $display("FAIL nobypass_next: got %h expected 1234", if_b.data1); end
    n_cmp++; if (if_a.data1 !== 32'h1234) begin n_fail++; $display("FAIL bypass_stored: got %h expected 00001234", if_a.data1); end
    step();
  endtask

  task automatic test_scoreboard();
    idle(); issue_valid = 1; issue_rd = 7; rs2 = 7; #1;
    n_cmp++; if (if_a.busy2 !== 1'b0) begin n_fail++; $display("FAIL sb_issue_cycle: got busy2 %b expected 0", if_a.busy2); end
    step(); idle(); rs2 = 7; #1;
    n_cmp++; if (if_a.busy2 !== 1'b1 || if_a.hazard !== 1'b1) begin n_fail++; $display("FAIL sb_busy: got busy2 %b hazard %b expected 1/1", if_a.busy2, if_a.hazard); end
    n_cmp++; if (if_b.busy2 !== 1'b1) begin n_fail++; $display("FAIL sb_busy_b: got %b expected 1", if_b.busy2); end
    step(); wb_valid = 1; wb_rd = 7; wb_data = 32'h55; #1;
    n_cmp++; if (if_a.busy2 !== 1'b0 || if_a.data2 !== 32'h55 || if_a.hazard !== 1'b0) begin n_fail++; $display("FAIL sb_wb_bypass: got busy2 %b data2 %h hazard %b expected 0/00000055/0", if_a.busy2, if_a.data2, if_a.hazard); end
    n_cmp++; if (if_b.busy2 !== 1'b1 || if_b.data2 !== 16'h0) begin n_fail++; $display("FAIL sb_wb_nobypass: got busy2 %b data2 %h expected 1/0000", if_b.busy2, if_b.data2); end
    step(); idle(); rs2 = 7; #1;
    n_cmp++; if (if_b.busy2 !== 1'b0 || if_b.data2 !== 16'h55) begin n_fail++; $display("FAIL sb_after_wb_b: got busy2 %b data2 %h expected 0/0055", if_b.busy2, if_b.data2); end
    step();
  endtask

  task automatic test_waw();
    idle(); issue_valid = 1; issue_rd = 9; step();
    rs1 = 9; #1;
    n_cmp++; if (if_a.issue_block !== 1'b1) begin n_fail++; $display("FAIL waw_block: got %b expected 1", if_a.issue_block); end
    step(); idle(); rs1 = 9; #1;
    n_cmp++; if (if_a.busy1 !== 1'b1) begin n_fail++; $display("FAIL waw_pending_kept: got %b expected 1", if_a.busy1); end
    wb_valid = 1; wb_rd = 9; wb_data = 32'h99; issue_valid = 1; issue_rd = 9; #1;
    n_cmp++; if (if_a.issue_block !== 1'b0) begin n_fail++; $display("FAIL waw_coincide_block: got %b expected 0", if_a.issue_block); end
    step(); idle(); rs1 = 9; #1;
    n_cmp++; if (if_a.data1 !== 32'h99 || if_a.busy1 !== 1'b1) begin n_fail++; $display("FAIL waw_coincide_after: got data1 %h busy1 %b expected 00000099/1", if_a.data1, if_a.busy1); end
    wb_valid = 1; wb_rd = 9; wb_data = 32'h99; step(); idle();
  endtask

  // ---------------- randomized cross-check ----------------
  task automatic test_random();
    logic [31:0] od1, od2;
    logic        ob1, ob2, oh, oib;
    logic [4:0]  lim;
    for (int c = 0; c < 10000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      lim = ($urandom_range(0, 1) == 1) ? 5'd7 : 5'd31;
      rs1 = 5'($urandom_range(0, int'(lim)));
      rs2 = ($urandom_range(0, 7) == 0) ? rs1 : 5'($urandom_range(0, int'(lim)));
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd = 5'($urandom_range(0, int'(lim)));
      wb_valid = 1'($urandom_range(0, 1));
      wb_rd = ($urandom_range(0, 3) == 0) ? issue_rd : 5'($urandom_range(0, int'(lim)));
      wb_data = $urandom;
      #1;
      for (int d = 0; d < 2; d++) begin
        if (d == 0) begin
          od1 = if_a.data1; od2 = if_a.data2; ob1 = if_a.busy1; ob2 = if_a.busy2;
          oh = if_a.hazard; oib = if_a.issue_block;
        end else begin
          od1 = {16'h0, if_b.data1}; od2 = {16'h0, if_b.data2}; ob1 = if_b.busy1; ob2 = if_b.busy2;
          oh = if_b.hazard; oib = if_b.issue_block;
        end
        n_cmp++; if (od1 !== m_read(d, rs1)) begin n_fail++; $display("FAIL rnd_data1 dut%0d cyc%0d: got %h expected %h", d, c, od1, m_read(d, rs1)); end
        n_cmp++; if (od2 !== m_read(d, rs2)) begin n_fail++; $display("FAIL rnd_data2 dut%0d cyc%0d: got %h expected %h", d, c, od2, m_read(d, rs2)); end
        n_cmp++; if (ob1 !== m_busy(d, rs1)) begin n_fail++; $display("FAIL rnd_busy1 dut%0d cyc%0d: got %b expected %b", d, c, ob1, m_busy(d, rs1)); end
        n_cmp++; if (ob2 !== m_busy(d, rs2)) begin n_fail++; $display("FAIL rnd_busy2 dut%0d cyc%0d: got %b expected %b", d, c, ob2, m_busy(d, rs2)); end
        n_cmp++; if (oh !== (m_busy(d, rs1) | m_busy(d, rs2))) begin n_fail++; $display("FAIL rnd_hazard dut%0d cyc%0d: got %b expected %b", d, c, oh, m_busy(d, rs1) | m_busy(d, rs2)); end
        n_cmp++; if (oib !== m_block(d)) begin n_fail++; $display("FAIL rnd_issue_block dut%0d cyc%0d: got %b expected %b", d, c, oib, m_block(d)); end
      end
      step();
    end
    rst = 0; idle();
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1;
    idle();
    test_reset();
    test_x0();
    test_bypass();
    test_scoreboard();
    test_waw();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
